// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: launches one load/store per MEM-stage request,
// holds the port for WAIT_CYCLES cycles, and returns the aligned, extended load data.
module dmem_access_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 12
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              MEM_VALID,
    input  logic              MEM_READ,
    input  logic              MEM_WRITE,
    input  logic [2:0]        FUNCT3,
    input  logic [31:0]       ADDR,
    input  logic [31:0]       WDATA,
    input  logic [31:0]       D_MEM_DI,
    output logic              D_MEM_CSN,
    output logic              D_MEM_WEN,
    output logic [3:0]        D_MEM_BE,
    output logic [ADDR_W-1:0] D_MEM_ADDR,
    output logic [31:0]       D_MEM_DOUT,
    output logic [31:0]       LOAD_DATA,
    output logic              STALL,
    output logic              ACC_ERR
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             read_r;
    logic [2:0]       funct3_r;
    logic [1:0]       offset_r;

    logic             req_s;
    logic             legal_s;
    logic             launch_s;
    logic             unused_s;

    // Stores only accept B/H/W; loads also accept BU/HU. H and W need natural alignment.
    function automatic logic f_legal(input logic is_write, input logic [2:0] f3,
                                     input logic [1:0] off);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~off[0];
            3'b010:  ok = (off == 2'b00);
            3'b100:  ok = ~is_write;
            3'b101:  ok = ~is_write & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {24'd0, wd[7:0]} << {off, 3'b000};
            2'b01:   d = {16'd0, wd[15:0]} << {off, 3'b000};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] di);
        logic [31:0] lane;
        logic [31:0] r;
        lane = di >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{lane[7]}}, lane[7:0]};
            3'b001:  r = {{16{lane[15]}}, lane[15:0]};
            3'b100:  r = {24'd0, lane[7:0]};
            3'b101:  r = {16'd0, lane[15:0]};
            default: r = di;
        endcase
        return r;
    endfunction

    assign unused_s = ^ADDR[31:ADDR_W];

    // Request decode plus the combinational handshake; both are silenced while reset is held.
    always_comb begin
        req_s    = MEM_VALID & (MEM_READ | MEM_WRITE);
        legal_s  = f_legal(MEM_WRITE, FUNCT3, ADDR[1:0]);
        launch_s = 1'b0;
        STALL    = 1'b0;
        ACC_ERR  = 1'b0;
        if (RSTn && (state_r == IDLE)) begin
            launch_s = req_s & legal_s;
            STALL    = req_s & legal_s;
            ACC_ERR  = req_s & ~legal_s;
        end else if (RSTn && (state_r == ACCESS)) begin
            STALL    = 1'b1;
        end else begin
            STALL    = 1'b0;
        end
    end

    // Access sequencer and registered memory-port outputs.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            read_r     <= 1'b0;
            funct3_r   <= 3'b000;
            offset_r   <= 2'b00;
            D_MEM_CSN  <= 1'b1;
            D_MEM_WEN  <= 1'b1;
            D_MEM_BE   <= 4'b0000;
            D_MEM_ADDR <= {ADDR_W{1'b0}};
            D_MEM_DOUT <= 32'd0;
            LOAD_DATA  <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (launch_s) begin
                        state_r    <= ACCESS;
                        cnt_r      <= CNT_W'(WAIT_CYCLES - 1);
                        read_r     <= ~MEM_WRITE;
                        funct3_r   <= FUNCT3;
                        offset_r   <= ADDR[1:0];
                        D_MEM_CSN  <= 1'b0;
                        D_MEM_WEN  <= ~MEM_WRITE;
                        D_MEM_BE   <= f_be(FUNCT3, ADDR[1:0]);
                        D_MEM_ADDR <= {ADDR[ADDR_W-1:2], 2'b00};
                        D_MEM_DOUT <= f_wdata(FUNCT3, ADDR[1:0], WDATA);
                    end
                end
                ACCESS: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        if (read_r) begin
                            LOAD_DATA <= f_extend(funct3_r, offset_r, D_MEM_DI);
                        end
                        D_MEM_CSN <= 1'b1;
                        D_MEM_WEN <= 1'b1;
                        D_MEM_BE  <= 4'b0000;
                        state_r   <= DONE;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                // The pipeline advances on this edge, so the lingering request is not relaunched.
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios with literal expectations, then random
// traffic compared every cycle against a timeline-based model of the access protocol.
module tb_dmem_access_ctrl;

    localparam int W = 2;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        MEM_VALID = 1'b0;
    logic        MEM_READ = 1'b0;
    logic        MEM_WRITE = 1'b0;
    logic [2:0]  FUNCT3 = 3'b000;
    logic [31:0] ADDR = 32'd0;
    logic [31:0] WDATA = 32'd0;
    logic [31:0] D_MEM_DI = 32'd0;
    logic        D_MEM_CSN;
    logic        D_MEM_WEN;
    logic [3:0]  D_MEM_BE;
    logic [11:0] D_MEM_ADDR;
    logic [31:0] D_MEM_DOUT;
    logic [31:0] LOAD_DATA;
    logic        STALL;
    logic        ACC_ERR;

    int total = 0;
    int bad   = 0;

    dmem_access_ctrl #(.WAIT_CYCLES(W), .ADDR_W(12)) dut (
        .CLK(CLK), .RSTn(RSTn), .MEM_VALID(MEM_VALID), .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE), .FUNCT3(FUNCT3), .ADDR(ADDR), .WDATA(WDATA),
        .D_MEM_DI(D_MEM_DI), .D_MEM_CSN(D_MEM_CSN), .D_MEM_WEN(D_MEM_WEN),
        .D_MEM_BE(D_MEM_BE), .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_DOUT(D_MEM_DOUT),
        .LOAD_DATA(LOAD_DATA), .STALL(STALL), .ACC_ERR(ACC_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_legal(bit wr, logic [2:0] f3, logic [31:0] a);
        bit f3ok;
        bit aligned;
        if (wr) f3ok = (f3 <= 3'd2);
        else    f3ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (f3[1:0] == 2'd1)      aligned = (a[0] == 1'b0);
        else if (f3[1:0] == 2'd2) aligned = (a[1:0] == 2'd0);
        else                      aligned = 1'b1;
        return f3ok && aligned;
    endfunction

    function automatic logic [3:0] m_be(logic [2:0] f3, logic [1:0] off);
        int nb = 1 << f3[1:0];
        int v;
        if (nb >= 4) return 4'hF;
        v = ((1 << nb) - 1) << off;
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_dout(logic [2:0] f3, logic [1:0] off, logic [31:0] wd);
        int nb = 1 << f3[1:0];
        logic [31:0] mask;
        if (nb >= 4) return wd;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        return (wd & mask) << (8 * off);
    endfunction

    function automatic logic [31:0] m_ext(logic [2:0] f3, logic [1:0] off, logic [31:0] di);
        int nb = 1 << f3[1:0];
        logic [31:0] lane;
        logic [31:0] mask;
        if (nb >= 4) return di;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        lane = (di >> (8 * off)) & mask;
        if (!f3[2] && lane[8 * nb - 1]) lane = lane | ~mask;
        return lane;
    endfunction

    bit          started = 1'b0;
    bit          busy = 1'b0;
    int          cyc = 0;
    int          launch_c = 0;
    bit          m_wr = 1'b0;
    logic [2:0]  m_f3 = 3'b000;
    logic [1:0]  m_off = 2'b00;
    logic [3:0]  m_be_r = 4'h0;
    logic [11:0] m_addr = 12'h000;
    logic [31:0] m_dq = 32'd0;
    logic [31:0] m_load = 32'd0;

    wire m_req = MEM_VALID & (MEM_READ | MEM_WRITE);

    // Model: an access launched in cycle L occupies cycles L+1..L+W, completes in L+W+1.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!RSTn) begin
            started <= 1'b1;
            busy    <= 1'b0;
            m_load  <= 32'd0;
            m_addr  <= 12'h000;
            m_dq    <= 32'd0;
        end else if (!busy) begin
            if (m_req && m_legal(MEM_WRITE, FUNCT3, ADDR)) begin
                busy     <= 1'b1;
                launch_c <= cyc;
                m_wr     <= MEM_WRITE;
                m_f3     <= FUNCT3;
                m_off    <= ADDR[1:0];
                m_be_r   <= m_be(FUNCT3, ADDR[1:0]);
                m_addr   <= {ADDR[11:2], 2'b00};
                m_dq     <= m_dout(FUNCT3, ADDR[1:0], WDATA);
            end
        end else begin
            if (cyc == launch_c + W && !m_wr) m_load <= m_ext(m_f3, m_off, D_MEM_DI);
            if (cyc == launch_c + W + 1) busy <= 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (started) begin
            bit in_acc;
            bit idle;
            bit lg;
            in_acc = busy && (cyc > launch_c) && (cyc <= launch_c + W);
            idle   = !busy;
            lg     = m_legal(MEM_WRITE, FUNCT3, ADDR);
            chk("stall",   {31'd0, STALL},   {31'd0, RSTn && (in_acc || (idle && m_req && lg))});
            chk("acc_err", {31'd0, ACC_ERR}, {31'd0, RSTn && idle && m_req && !lg});
            chk("csn",     {31'd0, D_MEM_CSN}, {31'd0, !in_acc});
            chk("wen",     {31'd0, D_MEM_WEN}, {31'd0, !(in_acc && m_wr)});
            chk("be",      {28'd0, D_MEM_BE},  {28'd0, in_acc ? m_be_r : 4'h0});
            chk("addr",    {20'd0, D_MEM_ADDR}, {20'd0, m_addr});
            chk("dout",    D_MEM_DOUT, m_dq);
            chk("load",    LOAD_DATA,  m_load);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] di);
        MEM_VALID = v; MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3;
        ADDR = a; WDATA = wd; D_MEM_DI = di;
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] di,
                             output int n_stall, output int n_csn, output int n_wen,
                             output logic [3:0] be, output logic [11:0] da,
                             output logic [31:0] dq);
        drive(1'b1, rd, wr, f3, a, wd, di);
        n_stall = 0; n_csn = 0; n_wen = 0; be = 4'h0; da = 12'h000; dq = 32'd0;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge CLK);
            #1;
            n_stall += int'(STALL);
            n_csn   += int'(!D_MEM_CSN);
            n_wen   += int'(!D_MEM_WEN);
            if (k == 1) begin
                be = D_MEM_BE; da = D_MEM_ADDR; dq = D_MEM_DOUT;
            end
            tick();
        end
    endtask

    initial begin
        int ns, nc, nw;
        logic [3:0]  be;
        logic [11:0] da;
        logic [31:0] dq;

        // Reset held two cycles with a live request.
        RSTn = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'h11111111);
        tick(); tick();
        chk("rst_csn",  {31'd0, D_MEM_CSN}, 32'd1);
        chk("rst_wen",  {31'd0, D_MEM_WEN}, 32'd1);
        chk("rst_be",   {28'd0, D_MEM_BE},  32'd0);
        chk("rst_stall", {31'd0, STALL},    32'd0);
        chk("rst_load", LOAD_DATA, 32'd0);

        // Abort: reset in the first ACCESS cycle of a load.
        RSTn = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 32'h12345678);
        #1 chk("abort_launch_stall", {31'd0, STALL}, 32'd1);
        tick();
        chk("abort_acc_csn", {31'd0, D_MEM_CSN}, 32'd0);
        RSTn = 1'b0;
        tick();
        chk("abort_csn",  {31'd0, D_MEM_CSN}, 32'd1);
        chk("abort_load", LOAD_DATA, 32'd0);
        RSTn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h12345678);
        tick();
        chk("abort_idle_csn", {31'd0, D_MEM_CSN}, 32'd1);
        chk("abort_idle_load", LOAD_DATA, 32'd0);

        // SW 0x104.
        do_access(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'd0, ns, nc, nw, be, da, dq);
        chk("sw_stall_cycles", ns, 32'd3);
        chk("sw_csn_cycles", nc, 32'd2);
        chk("sw_wen_cycles", nw, 32'd2);
        chk("sw_be", {28'd0, be}, 32'hF);
        chk("sw_addr", {20'd0, da}, 32'h104);
        chk("sw_dout", dq, 32'hDEADBEEF);

        // Sub-word loads from 0x80ABCDEF.
        do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80ABCDEF, ns, nc, nw, be, da, dq);
        chk("lb_be", {28'd0, be}, 32'h8);
        chk("lb_wen_cycles", nw, 32'd0);
        chk("lb_data", LOAD_DATA, 32'hFFFFFF80);
        do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80ABCDEF, ns, nc, nw, be, da, dq);
        chk("lbu_data", LOAD_DATA, 32'h00000080);
        do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 32'h80ABCDEF, ns, nc, nw, be, da, dq);
        chk("lh_be", {28'd0, be}, 32'hC);
        chk("lh_data", LOAD_DATA, 32'hFFFF80AB);

        // SH 0x102.
        do_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 32'd0, ns, nc, nw, be, da, dq);
        chk("sh_be", {28'd0, be}, 32'hC);
        chk("sh_dout", dq, 32'h12340000);
        chk("sh_wen_cycles", nw, 32'd2);
        chk("sh_load_held", LOAD_DATA, 32'hFFFF80AB);

        // LW held through DONE then an immediately following SW.
        do_access(1'b1, 1'b0, 3'b010, 32'h108, 32'd0, 32'hCAFEF00D, ns, nc, nw, be, da, dq);
        chk("lw_one_access", nc, 32'd2);
        chk("lw_data", LOAD_DATA, 32'hCAFEF00D);
        do_access(1'b0, 1'b1, 3'b000, 32'h10D, 32'h000000A5, 32'd0, ns, nc, nw, be, da, dq);
        chk("b2b_sw_stall", ns, 32'd3);
        chk("b2b_sw_be", {28'd0, be}, 32'h2);
        chk("b2b_sw_dout", dq, 32'h0000A500);

        // Illegal accesses.
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 32'd0);
        #1;
        chk("mis_err", {31'd0, ACC_ERR}, 32'd1);
        chk("mis_stall", {31'd0, STALL}, 32'd0);
        tick();
        chk("mis_csn", {31'd0, D_MEM_CSN}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 32'd0);
        #1;
        chk("f3_err", {31'd0, ACC_ERR}, 32'd1);
        chk("f3_stall", {31'd0, STALL}, 32'd0);
        tick();
        chk("f3_csn", {31'd0, D_MEM_CSN}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
        tick();

        // Random traffic checked by the per-cycle model.
        for (int i = 0; i < 3000; i++) begin
            RSTn = ($urandom_range(0, 149) != 0);
            D_MEM_DI = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                MEM_VALID = ($urandom_range(0, 3) != 0);
                MEM_READ  = $urandom_range(0, 1);
                MEM_WRITE = $urandom_range(0, 1);
                FUNCT3    = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7))
                                                        : 3'($urandom_range(0, 2));
                if ($urandom_range(0, 2) == 0 && !MEM_WRITE) FUNCT3 = FUNCT3 | 3'b100;
                ADDR  = $urandom;
                WDATA = $urandom;
            end
            tick();
        end
        RSTn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
        tick(); tick(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every load/store issued by the MEM stage onto the data-memory port. Memory has a fixed number of wait states.
- Drives D_MEM_CSN, D_MEM_WEN, D_MEM_BE, address and write data.
- Produces the aligned, extended load result.
- Asserts STALL so the pipeline registers hold (ENABLE = ~STALL) until the access completes.

Parameters:
- WAIT_CYCLES, 2, cycles the memory port is held active per access (legal range 1..15).
- ADDR_W, 12, width of D_MEM_ADDR (byte address).

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  synchronous active-low reset.
- MEM_VALID  in  1  MEM stage holds a valid instruction.
- MEM_READ  in  1  instruction is a load.
- MEM_WRITE  in  1  instruction is a store.
- FUNCT3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ADDR  in  32  byte address from the ALU.
- WDATA  in  32  store data (rs2).
- D_MEM_DI  in  32  read data from memory.
- D_MEM_CSN  out  1  chip select, active low.
- D_MEM_WEN  out  1  write enable, active low.
- D_MEM_BE  out  4  byte enables.
- D_MEM_ADDR  out  ADDR_W  word-aligned byte address.
- D_MEM_DOUT  out  32  lane-shifted write data.
- LOAD_DATA  out  32  extended load result.
- STALL  out  1  hold the pipeline.
- ACC_ERR  out  1  misaligned or illegal access.

Behaviour:
- **Reset.** Synchronous, on a CLK edge while RSTn=0:
  - state=IDLE, wait counter=0.
  - D_MEM_CSN=1, D_MEM_WEN=1, D_MEM_BE=0000, D_MEM_ADDR=0, D_MEM_DOUT=0, LOAD_DATA=0.
  - STALL=0, ACC_ERR=0.
  - RSTn low during ACCESS aborts the access: CSN=1 and IDLE after that edge, and no LOAD_DATA update.
- **Request.** req = MEM_VALID & (MEM_READ | MEM_WRITE). MEM_WRITE has priority when both are high.
- **Legality.**
  - Legal funct3: loads 000/001/010/100/101; stores 000/001/010.
  - Alignment: H requires ADDR[0]=0; W requires ADDR[1:0]=00.
  - Otherwise ACC_ERR=1, combinational, in IDLE only. No access is launched and STALL stays 0.
- **States: IDLE, ACCESS, DONE.** All memory-port outputs are registered.
  - IDLE:
    - STALL = req & legal, combinational.
    - On the edge with req & legal: capture op, BE, address and DOUT; counter=WAIT_CYCLES-1; go to ACCESS. CSN=0 and WEN=~write become visible from the next cycle.
  - ACCESS:
    - STALL=1; outputs held stable.
    - While counter != 0: counter decrements each edge.
    - On the edge with counter==0: for a read, LOAD_DATA <= extend(D_MEM_DI). Then CSN=1, WEN=1, BE=0000 and go to DONE.
    - ACCESS lasts exactly WAIT_CYCLES cycles.
  - DONE:
    - STALL=0, so the pipeline advances on this edge.
    - Unconditionally return to IDLE; the still-present request is not relaunched.
    - LOAD_DATA stays valid through DONE and holds until the next read completes.
- **Latency.** Request first seen in cycle t: STALL high for cycles t..t+WAIT_CYCLES (WAIT_CYCLES+1 cycles). DONE in cycle t+WAIT_CYCLES+1.
- **Byte enables.** With o = ADDR[1:0]:
  - B: 0001<<o.
  - H: 0011<<o.
  - W: 1111.
  - Loads use the same BE.
- **Write data.** D_MEM_DOUT = B: WDATA[7:0]<<8o; H: WDATA[15:0]<<8o; W: WDATA.
- **Address.** D_MEM_ADDR = {ADDR[ADDR_W-1:2], 2'b00}.
- **Load extend.** Select the lane at o and shift to bit 0. B/H sign-extend; BU/HU zero-extend; W passes through.

Test Plan:
1. Reset: hold RSTn=0 for 2 cycles with req=1 -> CSN=1, WEN=1, BE=0000, STALL=0, LOAD_DATA=0.
2. SW, ADDR=0x104, WDATA=0xDEADBEEF, WAIT_CYCLES=2:
   - STALL high 3 cycles.
   - 2 ACCESS cycles show CSN=0, WEN=0, BE=1111, ADDR=0x104, DOUT=0xDEADBEEF.
   - DONE has STALL=0 and CSN=1.
3. LB at ADDR=0x103, D_MEM_DI=0x80ABCDEF -> BE=1000, LOAD_DATA=0xFFFFFF80. Same access as LBU -> 0x00000080. LH at 0x102 -> 0xFFFF80AB.
4. SH at ADDR=0x102, WDATA=0x00001234 -> BE=1100, DOUT=0x12340000, WEN=0 for exactly 2 cycles.
5. LW at ADDR=0x102, then FUNCT3=011 load -> ACC_ERR=1, STALL=0, CSN stays 1, no state change.
6. Back-to-back and abort:
   - LW held through DONE -> exactly one access.
   - A following SW launches in the next IDLE cycle.
   - RSTn=0 in the first ACCESS cycle -> next edge IDLE, CSN=1, LOAD_DATA unchanged.
